muldiv_unit: RTL and testbench

- Multi-cycle RV32M multiply/divide unit; the sequential counterpart to the core's single-cycle combinational ALU.
- Sits beside the ALU in the execute stage. The core issues an operation with a valid/ready handshake, then stalls until the result handshake completes.
- Multiply is iterative shift-add; divide is restoring. Both run one bit per cycle on magnitudes, with sign correction at the end.

---
 rtl/muldiv_unit.sv | 186 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
//==============================================================================
// Module   : muldiv_unit
// Brief    : Multi-cycle RV32M multiply/divide (shift-add / restoring, 1 bit per
//            cycle). Optional macro ATOM_MULDIV_EARLY_OUT_EN: multiply early-out.
// Revision : 1.0
//==============================================================================
`default_nettype none

module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            result_valid_o,
    input  logic            result_ready_i,
    output logic [XLEN-1:0] result_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] c_OP_MUL    = 3'b000;
    localparam logic [2:0] c_OP_MULH   = 3'b001;
    localparam logic [2:0] c_OP_MULHSU = 3'b010;
    localparam logic [2:0] c_OP_DIV    = 3'b100;
    localparam logic [2:0] c_OP_REM    = 3'b110;

    state_t              r_state;
    state_t              w_state_next;
    logic [2:0]          r_op;
    logic                r_neg_a;
    logic                r_neg_b;
    logic [CNT_W-1:0]    r_cnt;
    logic [XLEN-1:0]     r_opnd;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_result;

    // Operand decode for the accept cycle
    logic            w_accept;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_neg_a;
    logic            w_neg_b;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic            w_b_zero;
    logic            w_ovf;
    logic            w_fast;
    logic [XLEN-1:0] w_fast_result;

    assign w_accept   = valid_i && (r_state == S_IDLE) && !flush_i;
    assign w_a_signed = (op_i == c_OP_MULH) || (op_i == c_OP_MULHSU) ||
                        (op_i == c_OP_DIV)  || (op_i == c_OP_REM);
    assign w_b_signed = (op_i == c_OP_MULH) || (op_i == c_OP_DIV) || (op_i == c_OP_REM);
    assign w_neg_a    = w_a_signed && a_i[XLEN-1];
    assign w_neg_b    = w_b_signed && b_i[XLEN-1];
    assign w_abs_a    = w_neg_a ? -a_i : a_i;
    assign w_abs_b    = w_neg_b ? -b_i : b_i;
    assign w_b_zero   = (b_i == '0);
    assign w_ovf      = ((op_i == c_OP_DIV) || (op_i == c_OP_REM)) &&
                        (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == {XLEN{1'b1}});
    assign w_fast     = op_i[2] && (w_b_zero || w_ovf);

    always_comb begin
        w_fast_result = '0;
        if (w_b_zero)
            w_fast_result = op_i[1] ? a_i : {XLEN{1'b1}};
        else
            w_fast_result = op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // Multiply step: r_acc = {accumulator, remaining multiplier bits}
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

    // Divide step: r_acc = {partial remainder, dividend/quotient}
    logic [XLEN:0]     w_div_shift;
    logic              w_div_ge;
    logic [XLEN-1:0]   w_div_sub;
    logic [XLEN-1:0]   w_div_rem;
    logic [2*XLEN-1:0] w_div_next;
    assign w_div_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    assign w_div_sub   = w_div_shift[XLEN-1:0] - r_opnd;
    assign w_div_rem   = w_div_ge ? w_div_sub : w_div_shift[XLEN-1:0];
    assign w_div_next  = {w_div_rem, r_acc[XLEN-2:0], w_div_ge};

    logic              w_early;
    logic [2*XLEN-1:0] w_busy_next;
`ifdef ATOM_MULDIV_EARLY_OUT_EN
    // Low r_cnt bits of r_acc are the not-yet-consumed multiplier bits
    logic [XLEN-1:0] w_rem_mask;
    assign w_rem_mask  = ~({XLEN{1'b1}} << r_cnt);
    assign w_early     = !r_op[2] && ((r_acc[XLEN-1:0] & w_rem_mask) == '0);
    assign w_busy_next = r_op[2] ? w_div_next : (w_early ? (r_acc >> r_cnt) : w_mul_next);
`else
    assign w_early     = 1'b0;
    assign w_busy_next = r_op[2] ? w_div_next : w_mul_next;
`endif

    // Sign correction and result selection
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_fix_result;
    assign w_prod_fix = (r_neg_a ^ r_neg_b) ? -r_acc : r_acc;
    assign w_quo_fix  = (r_neg_a ^ r_neg_b) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem_fix  = r_neg_a ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

    always_comb begin
        w_fix_result = '0;
        case (r_op)
            c_OP_MUL:          w_fix_result = w_prod_fix[XLEN-1:0];
            3'b001, 3'b010,
            3'b011:            w_fix_result = w_prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:    w_fix_result = w_quo_fix;
            default:           w_fix_result = w_rem_fix;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_next = w_fast ? S_DONE : S_BUSY;
            S_BUSY: begin
                if (flush_i)
                    w_state_next = S_IDLE;
                else if (w_early || (r_cnt == CNT_W'(1)))
                    w_state_next = S_FIX;
            end
            S_FIX:  w_state_next = flush_i ? S_IDLE : S_DONE;
            S_DONE: if (flush_i || result_ready_i) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_cnt    <= '0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_op    <= op_i;
                r_neg_a <= w_neg_a;
                r_neg_b <= w_neg_b;
                r_cnt   <= CNT_W'(XLEN);
                r_opnd  <= op_i[2] ? w_abs_b : w_abs_a;
                r_acc   <= {{XLEN{1'b0}}, (op_i[2] ? w_abs_a : w_abs_b)};
                if (w_fast)
                    r_result <= w_fast_result;
            end else if (r_state == S_BUSY && !flush_i) begin
                r_acc <= w_busy_next;
                r_cnt <= r_cnt - CNT_W'(1);
            end else if (r_state == S_FIX && !flush_i) begin
                r_result <= w_fix_result;
            end
        end
    end

    assign ready_o        = (r_state == S_IDLE);
    assign result_valid_o = (r_state == S_DONE);
    assign result_o       = r_result;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
//==============================================================================
// Module   : tb_muldiv_unit
// Brief    : Directed self-checking bench for muldiv_unit.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        valid;
    logic        ready;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        rvalid;
    logic        rready;
    logic [31:0] result;

    int n_checks = 0;
    int n_pass   = 0;

    localparam int c_LIMIT = 100;

    muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .flush_i        (flush),
        .valid_i        (valid),
        .ready_o        (ready),
        .op_i           (op),
        .a_i            (a),
        .b_i            (b),
        .result_valid_o (rvalid),
        .result_ready_i (rready),
        .result_o       (result)
    );

    always #5 clk = ~clk;

    // Issue one request and wait (bounded) for result_valid_o; leaves unit in DONE.
    task automatic run_op(input logic [2:0] i_op, input logic [31:0] i_a, input logic [31:0] i_b,
                          output logic [31:0] o_res, output int o_lat);
        @(negedge clk);
        op = i_op; a = i_a; b = i_b; valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
        o_lat = 1;
        while (!rvalid && o_lat < c_LIMIT) begin
            @(posedge clk);
            #1;
            o_lat++;
        end
        o_res = result;
    endtask

    task automatic consume();
        rready = 1'b1;
        @(posedge clk);
        #1;
        rready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (ready !== 1'b1) $display("FAIL reset_ready got %b expected 1", ready); else n_pass++;
        n_checks++;
        if (rvalid !== 1'b0) $display("FAIL reset_valid got %b expected 0", rvalid); else n_pass++;
        n_checks++;
        if (result !== 32'h0) $display("FAIL reset_result got %h expected 0", result); else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_mul_basic();
        logic [31:0] res;
        int          lat;
        run_op(3'b000, 32'd7, 32'd6, res, lat);
        n_checks++;
        if (res !== 32'h0000_002A) $display("FAIL mul_7x6 got %h expected 0000002a", res); else n_pass++;
        n_checks++;
`ifdef ATOM_MULDIV_EARLY_OUT_EN
        if (lat >= 34) $display("FAIL mul_7x6_latency got %0d expected <34", lat); else n_pass++;
`else
        if (lat != 34) $display("FAIL mul_7x6_latency got %0d expected 34", lat); else n_pass++;
`endif
        consume();
`ifdef ATOM_MULDIV_EARLY_OUT_EN
        run_op(3'b000, 32'd9, 32'd0, res, lat);
        n_checks++;
        if (res !== 32'h0) $display("FAIL mul_by_zero got %h expected 0", res); else n_pass++;
        n_checks++;
        if (lat != 3) $display("FAIL mul_by_zero_latency got %0d expected 3", lat); else n_pass++;
        consume();
`endif
    endtask

    task automatic test_mul_family();
        logic [2:0]  t_op [5] = '{3'b001, 3'b011, 3'b010, 3'b000, 3'b001};
        logic [31:0] t_a  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] t_b  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] t_e  [5] = '{32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0001, 32'h4000_0000};
        logic [31:0] res;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], res, lat);
            n_checks++;
            if (res !== t_e[i])
                $display("FAIL mul_family[%0d] op=%b got %h expected %h", i, t_op[i], res, t_e[i]);
            else n_pass++;
            consume();
        end
    endtask

    task automatic test_div();
        logic [2:0]  t_op [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] t_a  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] t_b  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] t_e  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        logic [31:0] res;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], res, lat);
            n_checks++;
            if (res !== t_e[i])
                $display("FAIL div[%0d] op=%b got %h expected %h", i, t_op[i], res, t_e[i]);
            else n_pass++;
            n_checks++;
            if (lat != 34) $display("FAIL div_latency[%0d] got %0d expected 34", i, lat); else n_pass++;
            consume();
        end
    endtask

    task automatic test_div_fast();
        logic [2:0]  t_op [6] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110};
        logic [31:0] t_a  [6] = '{32'd5, 32'd5, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] t_b  [6] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] t_e  [6] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        logic [31:0] res;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], res, lat);
            n_checks++;
            if (res !== t_e[i])
                $display("FAIL div_fast[%0d] op=%b got %h expected %h", i, t_op[i], res, t_e[i]);
            else n_pass++;
            n_checks++;
            if (lat != 1) $display("FAIL div_fast_latency[%0d] got %0d expected 1", i, lat); else n_pass++;
            consume();
        end
    endtask

    task automatic test_hold();
        logic [31:0] res;
        int          lat;
        int          bad = 0;
        run_op(3'b000, 32'd3, 32'd5, res, lat);
        // New requests presented during DONE must be ignored
        valid = 1'b1; op = 3'b100; a = 32'd1; b = 32'd0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (result !== 32'd15 || rvalid !== 1'b1 || ready !== 1'b0) bad++;
        end
        valid = 1'b0;
        n_checks++;
        if (bad != 0) $display("FAIL hold_stable got %0d bad cycles expected 0 (result=%h)", bad, result);
        else n_pass++;
        consume();
        n_checks++;
        if (ready !== 1'b1 || rvalid !== 1'b0)
            $display("FAIL hold_release got ready=%b valid=%b expected ready=1 valid=0", ready, rvalid);
        else n_pass++;
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int          lat;
        int          seen = 0;
        @(negedge clk);
        op = 3'b000; a = 32'h1234_5678; b = 32'hFFFF_FFFF; valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        n_checks++;
        if (ready !== 1'b1 || rvalid !== 1'b0)
            $display("FAIL flush_busy got ready=%b valid=%b expected ready=1 valid=0", ready, rvalid);
        else n_pass++;
        n_checks++;
        if (result !== 32'd15) $display("FAIL flush_keeps_result got %h expected 0000000f", result);
        else n_pass++;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (rvalid) seen++;
        end
        n_checks++;
        if (seen != 0) $display("FAIL flush_no_valid got %0d valid cycles expected 0", seen); else n_pass++;
        run_op(3'b000, 32'd3, 32'd3, res, lat);
        n_checks++;
        if (res !== 32'd9) $display("FAIL flush_then_mul got %h expected 00000009", res); else n_pass++;
        consume();

        // Flush while idle blocks acceptance of a would-be fast-path request
        @(negedge clk);
        op = 3'b100; a = 32'd1; b = 32'd0; valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0; flush = 1'b0;
        n_checks++;
        if (ready !== 1'b1 || rvalid !== 1'b0)
            $display("FAIL flush_idle got ready=%b valid=%b expected ready=1 valid=0", ready, rvalid);
        else n_pass++;

        // Flush in DONE drops the result but keeps result_o
        run_op(3'b101, 32'd7, 32'd0, res, lat);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        n_checks++;
        if (ready !== 1'b1 || rvalid !== 1'b0 || result !== 32'hFFFF_FFFF)
            $display("FAIL flush_done got ready=%b valid=%b result=%h expected 1 0 ffffffff",
                     ready, rvalid, result);
        else n_pass++;
    endtask

    task automatic test_reset_mid_busy();
        logic [31:0] res;
        int          lat;
        @(negedge clk);
        op = 3'b011; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_checks++;
        if (ready !== 1'b1 || rvalid !== 1'b0 || result !== 32'h0)
            $display("FAIL reset_mid_busy got ready=%b valid=%b result=%h expected 1 0 00000000",
                     ready, rvalid, result);
        else n_pass++;
        run_op(3'b000, 32'd2, 32'd3, res, lat);
        n_checks++;
        if (res !== 32'd6) $display("FAIL after_reset_mul got %h expected 00000006", res); else n_pass++;
        consume();
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; valid = 1'b0; rready = 1'b0;
        op = 3'b000; a = 32'h0; b = 32'h0;
        test_reset();
        test_mul_basic();
        test_mul_family();
        test_div();
        test_div_fast();
        test_hold();
        test_flush();
        test_reset_mid_busy();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
